apb4_master: RTL and testbench
==============================

APB4_MASTER -- requirements
Module: apb4_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width; STRB width = DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum ACCESS cycles; 0 disables timeout.
REQ-004 SHALL have port pclk, input, 1, the single clock for the block.
REQ-005 SHALL have port presetn, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have ports req_valid_i (in, 1) and req_ready_o (out, 1), the command handshake.
REQ-007 SHALL have ports req_write_i (in, 1), req_addr_i (in, ADDR_WIDTH), req_wdata_i (in, DATA_WIDTH), req_strb_i (in, STRB), req_prot_i (in, 3), the command payload.
REQ-008 SHALL have ports rsp_valid_o (out, 1) and rsp_ready_i (in, 1), the response handshake.
REQ-009 SHALL have ports rsp_rdata_o (out, DATA_WIDTH), rsp_err_o (out, 1) and rsp_timeout_o (out, 1), the response payload.
REQ-010 SHALL have APB4 outputs paddr (ADDR_WIDTH), pprot (3), psel (1), penable (1), pwrite (1), pwdata (DATA_WIDTH) and pstrb (STRB).
REQ-011 SHALL have APB4 inputs pready (1), prdata (DATA_WIDTH) and pslverr (1).

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP; all outputs SHALL be registered or decoded only from state.
REQ-013 req_ready_o SHALL be 1 only in IDLE.
REQ-014 IDLE: when req_valid_i=1, SHALL capture the payload into registers and go to SETUP next cycle.
REQ-015 SETUP: psel=1, penable=0, APB address/control/data driven from captured registers; SHALL go to ACCESS unconditionally after 1 cycle.
REQ-016 ACCESS: psel=1, penable=1; paddr, pwrite, pwdata, pstrb and pprot SHALL stay stable until exit.
REQ-017 ACCESS with pready=1: SHALL capture rsp_err_o=pslverr, rsp_timeout_o=0, rsp_rdata_o=prdata for reads (0 for writes); SHALL go to RESP.
REQ-018 pstrb SHALL be driven to all-zero for reads, regardless of req_strb_i.
REQ-019 Timeout: a counter SHALL clear on SETUP entry and increment each ACCESS cycle with pready=0.
REQ-020 Timeout exit: when the counter reaches TIMEOUT_CYCLES-1 with pready=0, SHALL go to RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-021 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1), with a minimum of 1; the counter SHALL saturate rather than wrap.
REQ-022 pready=1 on the same cycle as the timeout threshold SHALL count as normal completion (pready wins).
REQ-023 RESP: psel=0, penable=0, rsp_valid_o=1; the response payload SHALL stay stable until rsp_ready_i=1, then go to IDLE.
REQ-024 Minimum transfer SHALL be 4 cycles, one cycle each of IDLE accept, SETUP, ACCESS and RESP; no overlap of transfers.
REQ-025 Outside SETUP/ACCESS: psel=0 and penable=0; paddr/pwdata SHALL hold their last values.
REQ-026 pready, prdata and pslverr SHALL be ignored outside ACCESS.

Reset
REQ-027 presetn=0 at a pclk edge SHALL force IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, pprot=0.
REQ-028 The same reset SHALL force rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, rsp_timeout_o=0 and the timeout counter to 0.
REQ-029 Reset asserted mid-transfer (SETUP/ACCESS/RESP) SHALL abort it with no response; the pending response SHALL be discarded.
REQ-030 req_ready_o SHALL be 1 from the first cycle after reset release.

Verification
REQ-031 Write addr 0x0000_0008, data 0xA5A5_5A5A, strb 0xF, pready=1 -> SETUP then ACCESS each 1 cycle, pwrite=1, rsp_err_o=0, rsp_rdata_o=0.
REQ-032 Read addr 0x4, slave holds pready=0 for 3 ACCESS cycles then returns prdata=0x1234_5678 -> 4 ACCESS cycles, pstrb=0, rsp_rdata_o=0x1234_5678.
REQ-033 Write with pslverr=1 on completion -> rsp_err_o=1, rsp_timeout_o=0; next command accepted after rsp_ready_i.
REQ-034 TIMEOUT_CYCLES=4, pready held 0 -> psel drops after 4 ACCESS cycles, rsp_err_o=1, rsp_timeout_o=1; with TIMEOUT_CYCLES=0 the transfer waits indefinitely.
REQ-035 rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and payload stable, req_ready_o=0 throughout.
REQ-036 presetn=0 during ACCESS -> next cycle psel=0, penable=0, rsp_valid_o=0, req_ready_o=1 after release.

Source files
------------

// File: rtl/apb4_master.sv
// APB4 master bridge: accepts one command on a valid/ready handshake, runs it as a single
// APB4 transfer (SETUP, then ACCESS until pready or timeout), and returns the result on a
// valid/ready response channel. Only one transfer is in flight at a time.
//
// Ports
//   pclk, presetn                     clock, synchronous active-low reset
//   req_valid_i / req_ready_o         command handshake (ready only when idle)
//   req_write_i, req_addr_i,
//   req_wdata_i, req_strb_i,
//   req_prot_i                        command payload
//   rsp_valid_o / rsp_ready_i         response handshake
//   rsp_rdata_o, rsp_err_o,
//   rsp_timeout_o                     response payload
//   paddr, pprot, psel, penable,
//   pwrite, pwdata, pstrb             APB4 requester outputs
//   pready, prdata, pslverr           APB4 completer inputs (sampled only in ACCESS)
module apb4_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]              pprot,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned CntW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] TimeoutLast =
      CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [2:0]              pprot_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [StrbW-1:0]        pstrb_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;
  logic                    rsp_timeout_q;
  logic [CntW-1:0]         cnt_q;
  logic                    timeout_hit;
  logic                    accept;

  assign accept = (state_q == StIdle) && req_valid_i;

  // Threshold only fires while pready is low, so a same-cycle pready completes normally.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !pready && (cnt_q == TimeoutLast);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid_i) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (pready || timeout_hit) state_d = StResp;
      StResp:   if (rsp_ready_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      paddr_q       <= '0;
      pprot_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      if (accept) begin
        paddr_q  <= req_addr_i;
        pprot_q  <= req_prot_i;
        pwrite_q <= req_write_i;
        pwdata_q <= req_wdata_i;
        // Reads never carry byte strobes.
        pstrb_q  <= req_write_i ? req_strb_i : '0;
        cnt_q    <= '0;
      end
      if (state_q == StAccess) begin
        if (pready) begin
          rsp_err_q     <= pslverr;
          rsp_timeout_q <= 1'b0;
          rsp_rdata_q   <= pwrite_q ? '0 : prdata;
        end else begin
          if (timeout_hit) begin
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
          end
          if (cnt_q != '1) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
      end
    end
  end

  assign req_ready_o   = (state_q == StIdle);
  assign rsp_valid_o   = (state_q == StResp);
  assign psel          = (state_q == StSetup) || (state_q == StAccess);
  assign penable       = (state_q == StAccess);
  assign paddr         = paddr_q;
  assign pprot         = pprot_q;
  assign pwrite        = pwrite_q;
  assign pwdata        = pwdata_q;
  assign pstrb         = pstrb_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb4_master.sv
// Scoreboard bench for apb4_master. A driver issues commands and pushes the expected APB
// phase, completer behaviour and response into queues; a completer model answers ACCESS
// cycles; a monitor consumes responses and checks them against the queued expectations.
module tb_apb4_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    strb;
    logic [2:0]    prot;
  } apb_t;

  typedef struct {
    int            waits;
    logic          slverr;
    logic [DW-1:0] rdata;
    int            exp_acc;
  } plan_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  apb_t  apb_q[$];
  plan_t plan_q[$];
  rsp_t  rsp_q[$];

  int checks = 0;
  int errors = 0;

  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  // Main DUT (short timeout)
  logic          req_valid_i, req_ready_o, req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic [3:0]    req_strb_i;
  logic [2:0]    req_prot_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
  logic [DW-1:0] rsp_rdata_o;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;

  apb4_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .req_prot_i(req_prot_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  // Second DUT with timeout disabled
  logic          z_req_valid, z_req_ready, z_rsp_valid, z_rsp_err, z_rsp_tmo;
  logic [DW-1:0] z_rsp_rdata, z_pwdata, z_prdata;
  logic [AW-1:0] z_paddr;
  logic [2:0]    z_pprot;
  logic          z_psel, z_penable, z_pwrite, z_pready;
  logic [3:0]    z_pstrb;

  apb4_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut0 (
    .pclk(pclk), .presetn(presetn),
    .req_valid_i(z_req_valid), .req_ready_o(z_req_ready), .req_write_i(1'b0),
    .req_addr_i(32'h10), .req_wdata_i(32'h0), .req_strb_i(4'hF), .req_prot_i(3'b0),
    .rsp_valid_o(z_rsp_valid), .rsp_ready_i(1'b1), .rsp_rdata_o(z_rsp_rdata),
    .rsp_err_o(z_rsp_err), .rsp_timeout_o(z_rsp_tmo),
    .paddr(z_paddr), .pprot(z_pprot), .psel(z_psel), .penable(z_penable), .pwrite(z_pwrite),
    .pwdata(z_pwdata), .pstrb(z_pstrb), .pready(z_pready), .prdata(z_prdata),
    .pslverr(1'b0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one command; expectations are derived from the completer plan.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] s, input logic [2:0] p, input int waits,
                       input logic serr, input logic [DW-1:0] rd);
    int n = 0;
    apb_t  ea;
    plan_t pl;
    rsp_t  er;
    bit    tmo;
    while (!req_ready_o && n < 300) begin
      @(negedge pclk);
      n++;
    end
    if (!req_ready_o) begin
      check("req_ready_wait", 64'(req_ready_o), 64'd1);
      return;
    end
    tmo = (waits >= TO);
    ea = '{write: w, addr: a, wdata: d, strb: (w ? s : 4'h0), prot: p};
    pl = '{waits: waits, slverr: serr, rdata: rd, exp_acc: (tmo ? TO : waits + 1)};
    er = '{rdata: ((tmo || w) ? '0 : rd), err: (tmo ? 1'b1 : serr), tmo: tmo};
    apb_q.push_back(ea);
    plan_q.push_back(pl);
    rsp_q.push_back(er);
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = a;
    req_wdata_i = d;
    req_strb_i  = s;
    req_prot_i  = p;
    @(negedge pclk);
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    req_write_i = 1'(($urandom));
  endtask

  // Completer model
  initial begin : completer
    int    acc_cnt = 0;
    int    setup_cnt = 0;
    plan_t cur;
    apb_t  ea;
    cur = '{waits: 0, slverr: 1'b0, rdata: '0, exp_acc: 1};
    ea  = '{write: 1'b0, addr: '0, wdata: '0, strb: '0, prot: '0};
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        if (acc_cnt == 0) begin
          check("setup_cycles", 64'(setup_cnt), 64'd1);
          if (plan_q.size() == 0 || apb_q.size() == 0) begin
            check("unexpected_transfer", 64'd1, 64'd0);
          end else begin
            cur = plan_q.pop_front();
            ea  = apb_q.pop_front();
          end
        end
        setup_cnt = 0;
        check("paddr", 64'(paddr), 64'(ea.addr));
        check("pwrite", 64'(pwrite), 64'(ea.write));
        check("pstrb", 64'(pstrb), 64'(ea.strb));
        check("pprot", 64'(pprot), 64'(ea.prot));
        if (ea.write) check("pwdata", 64'(pwdata), 64'(ea.wdata));
        pready  = (acc_cnt == cur.waits);
        prdata  = cur.rdata;
        pslverr = cur.slverr;
        acc_cnt++;
      end else begin
        if (psel && !penable) setup_cnt++;
        if (acc_cnt != 0 && presetn) check("access_cycles", 64'(acc_cnt), 64'(cur.exp_acc));
        acc_cnt = 0;
        // Junk outside ACCESS must be ignored by the DUT.
        pready  = 1'(($urandom));
        prdata  = $urandom;
        pslverr = 1'(($urandom));
      end
    end
  end

  // Response monitor / consumer
  initial begin : monitor
    int   delay = 0;
    bit   holding = 0;
    rsp_t held, er;
    held = '{rdata: '0, err: 1'b0, tmo: 1'b0};
    rsp_ready_i = 1'b0;
    forever begin
      @(negedge pclk);
      if (rsp_valid_o && presetn) begin
        check("req_ready_in_resp", 64'(req_ready_o), 64'd0);
        if (holding) begin
          check("rsp_stable", {rsp_rdata_o, 30'd0, rsp_err_o, rsp_timeout_o},
                {held.rdata, 30'd0, held.err, held.tmo});
        end else begin
          holding = 1;
          held = '{rdata: rsp_rdata_o, err: rsp_err_o, tmo: rsp_timeout_o};
          delay = ($urandom_range(0, 3) == 0) ? 5 : int'($urandom_range(0, 2));
        end
        if (delay == 0) begin
          rsp_ready_i = 1'b1;
          holding = 0;
          if (rsp_q.size() == 0) begin
            check("unexpected_rsp", 64'd1, 64'd0);
          end else begin
            er = rsp_q.pop_front();
            check("rsp_rdata", 64'(rsp_rdata_o), 64'(er.rdata));
            check("rsp_err", 64'(rsp_err_o), 64'(er.err));
            check("rsp_timeout", 64'(rsp_timeout_o), 64'(er.tmo));
          end
        end else begin
          rsp_ready_i = 1'b0;
          delay--;
        end
      end else begin
        holding = 0;
        rsp_ready_i = 1'(($urandom));
      end
    end
  end

  initial begin : driver
    int n;
    int waits;
    presetn = 1'b0;
    req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    req_strb_i = '0; req_prot_i = '0;
    z_req_valid = 1'b0; z_pready = 1'b0; z_prdata = '0;
    @(negedge pclk);
    @(negedge pclk);
    check("rst_psel_penable", {62'd0, psel, penable}, 64'd0);
    check("rst_apb_ctrl", {56'd0, pwrite, pprot, pstrb}, 64'd0);
    check("rst_paddr_pwdata", {paddr, pwdata}, 64'd0);
    check("rst_rsp", {rsp_rdata_o, 29'd0, rsp_valid_o, rsp_err_o, rsp_timeout_o}, 64'd0);
    presetn = 1'b1;
    @(negedge pclk);
    check("req_ready_after_rst", 64'(req_ready_o), 64'd1);

    // Timeout disabled: ACCESS waits indefinitely
    z_req_valid = 1'b1;
    @(negedge pclk);
    z_req_valid = 1'b0;
    repeat (40) @(negedge pclk);
    check("no_timeout_still_access", {61'd0, z_psel, z_penable, z_rsp_valid}, 64'b110);
    z_pready = 1'b1;
    z_prdata = 32'hCAFE_0001;
    @(negedge pclk);
    z_pready = 1'b0;
    check("no_timeout_rsp", {z_rsp_rdata, 29'd0, z_rsp_valid, z_rsp_err, z_rsp_tmo},
          {32'hCAFE_0001, 29'd0, 3'b100});

    // Directed cases
    issue(1'b1, 32'h8, 32'hA5A5_5A5A, 4'hF, 3'd0, 0, 1'b0, 32'hDEAD_BEEF);
    issue(1'b0, 32'h4, 32'h0, 4'hF, 3'd2, 3, 1'b0, 32'h1234_5678);
    issue(1'b1, 32'h20, 32'h0BAD_F00D, 4'h3, 3'd1, 1, 1'b1, 32'h0);
    issue(1'b1, 32'h24, 32'h1111_2222, 4'hC, 3'd7, 9, 1'b0, 32'h0);
    issue(1'b0, 32'h28, 32'h0, 4'hF, 3'd0, TO, 1'b0, 32'h5555_AAAA);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      waits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TO, TO + 3))
                                          : int'($urandom_range(0, TO - 1));
      issue(1'(($urandom)), $urandom, $urandom, 4'(($urandom)), 3'(($urandom)), waits,
            1'(($urandom)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge pclk);
    end

    n = 0;
    while (rsp_q.size() != 0 && n < 500) begin
      @(negedge pclk);
      n++;
    end
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    repeat (3) @(negedge pclk);

    // Reset during ACCESS aborts the transfer with no response
    issue(1'b0, 32'h30, 32'h0, 4'hF, 3'd0, 20, 1'b0, 32'h7777_7777);
    n = 0;
    while (!(psel && penable) && n < 20) begin
      @(negedge pclk);
      n++;
    end
    check("reached_access", {62'd0, psel, penable}, 64'b11);
    @(negedge pclk);
    presetn = 1'b0;
    rsp_q.delete();
    @(negedge pclk);
    check("mid_rst_outputs", {61'd0, psel, penable, rsp_valid_o}, 64'd0);
    check("mid_rst_paddr", 64'(paddr), 64'd0);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check("mid_rst_ready", {62'd0, req_ready_o, rsp_valid_o}, 64'b10);
    repeat (5) @(negedge pclk);
    check("no_rsp_after_abort", 64'(rsp_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
